// File: rtl/sample_pkg.sv
// Shared sizing helpers and slot-control encoding for the sample buffer.
package sample_pkg;

  // What the output slot does on the coming clock edge.
  typedef enum logic [1:0] {
    SLOT_IDLE       = 2'd0,  // slot busy with unconsumed sample, keep it
    SLOT_LOAD_QUEUE = 2'd1,  // refill slot from the queue head
    SLOT_LOAD_DIN   = 2'd2,  // refill slot (or bypass) straight from din
    SLOT_DRAIN      = 2'd3   // slot freed, nothing fresh to load
  } slot_act_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Circular pointer width; depth is a power of two so pointers wrap for free.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sample_queue.sv
// Circular overwrite queue: on push while full (and no pop) the oldest entry
// is discarded and a one-cycle drop strobe is raised.
module sample_queue
  import sample_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        drop
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_QW = cnt_width(DEPTH);
  localparam logic [CNT_QW-1:0] CNT_FULL = CNT_QW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_QW-1:0] count_q, count_d;
  logic              do_pop;
  logic              mem_we;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer/count update; push-while-full without pop overwrites the oldest.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop     = 1'b0;
    mem_we   = 1'b0;
    do_pop   = pop && !empty;
    if (push) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else if (full) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        drop     = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sample_buf.sv
// Always-ready sampler: registered output slot backed by an overwrite queue,
// optional combinational bypass, optional hold of the last value, and a
// saturating count of discarded samples.
module sample_buf
  import sample_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter int                HOLD       = 1,
  parameter int                LATENCY    = 1,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] INIT       = '0,
  parameter bit                INIT_VALID = 1'b0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout_data,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic [DATA_W-1:0]           out_reg_q, out_reg_d;
  logic                        out_fresh_q, out_fresh_d;
  logic                        have_last_q, have_last_d;
  logic [CNT_W-1:0]            drop_cnt_q, drop_cnt_d;

  logic                        bypass;
  logic                        slot_free;
  slot_act_e                   slot_act;

  logic                        q_push;
  logic                        q_pop;
  logic [DATA_W-1:0]           q_head;
  logic [cnt_width(DEPTH)-1:0] q_count;
  logic                        q_full;
  logic                        q_empty;
  logic                        q_drop;
  logic                        unused_q_status;

  sample_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (din_data),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty),
    .drop  (q_drop)
  );

  // Occupancy detail is only needed inside the queue itself.
  assign unused_q_status = ^{q_count, q_full};

  // The producer is free-running and is never stalled.
  assign din_ready = 1'b1;

  // Bypass only when nothing older is waiting, so ordering is preserved.
  assign bypass     = (LATENCY == 0) && !out_fresh_q && q_empty && din_valid;
  assign dout_valid = out_fresh_q || bypass || ((HOLD != 0) && have_last_q);
  assign dout_data  = bypass ? din_data : out_reg_q;
  assign slot_free  = !out_fresh_q || dout_ready;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = q_drop;

  // Decide how the output slot is refilled on this edge.
  always_comb begin
    slot_act = SLOT_IDLE;
    if (slot_free) begin
      if (!q_empty) begin
        slot_act = SLOT_LOAD_QUEUE;
      end else if (din_valid) begin
        slot_act = SLOT_LOAD_DIN;
      end else begin
        slot_act = SLOT_DRAIN;
      end
    end
  end

  // Next-state for slot, hold flag, queue strobes and drop counter.
  always_comb begin
    out_reg_d   = out_reg_q;
    out_fresh_d = out_fresh_q;
    have_last_d = have_last_q;
    drop_cnt_d  = drop_cnt_q;
    q_pop       = 1'b0;
    // Any sample not taken directly into the slot goes to the queue.
    q_push      = din_valid && (slot_act != SLOT_LOAD_DIN);

    case (slot_act)
      SLOT_LOAD_QUEUE: begin
        out_reg_d   = q_head;
        out_fresh_d = 1'b1;
        q_pop       = 1'b1;
      end
      SLOT_LOAD_DIN: begin
        out_reg_d   = din_data;
        // A bypassed sample taken this cycle is already delivered.
        out_fresh_d = !(bypass && dout_ready);
      end
      SLOT_DRAIN: begin
        out_fresh_d = 1'b0;
      end
      default: begin
      end
    endcase

    if ((slot_act == SLOT_LOAD_QUEUE) || (slot_act == SLOT_LOAD_DIN) ||
        (dout_valid && dout_ready)) begin
      have_last_d = 1'b1;
    end

    if (q_drop) begin
      drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_MAX));
    end
  end

  // Slot, hold flag and drop counter; reset discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q   <= INIT;
      out_fresh_q <= 1'b0;
      have_last_q <= INIT_VALID;
      drop_cnt_q  <= '0;
    end else begin
      out_reg_q   <= out_reg_d;
      out_fresh_q <= out_fresh_d;
      have_last_q <= have_last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_sample_buf.sv
// Bench for sample_buf: three differently configured instances share one
// stimulus stream; a list-based reference model predicts each cycle's outputs
// into a scoreboard that a separate monitor drains on the falling edge.
module tb_sample_buf;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       din_valid;
  logic [7:0] din_data;
  logic       ready;

  logic [N-1:0] dinr;
  logic [N-1:0] dv;
  logic [7:0]   dd [N];
  logic [15:0]  dc [N];
  logic [N-1:0] ov;
  logic [1:0]   c1;
  logic [2:0]   c2;

  assign dc[1] = {14'b0, c1};
  assign dc[2] = {13'b0, c2};

  sample_buf #(.DEPTH(4), .HOLD(1), .LATENCY(0), .DATA_W(8), .INIT(8'h5A),
               .INIT_VALID(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_data(din_data),
    .din_ready(dinr[0]), .dout_valid(dv[0]), .dout_data(dd[0]),
    .dout_ready(ready), .drop_cnt(dc[0]), .overflow(ov[0]));

  sample_buf #(.DEPTH(4), .HOLD(0), .LATENCY(1), .DATA_W(8), .INIT(8'h5A),
               .INIT_VALID(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_data(din_data),
    .din_ready(dinr[1]), .dout_valid(dv[1]), .dout_data(dd[1]),
    .dout_ready(ready), .drop_cnt(c1), .overflow(ov[1]));

  sample_buf #(.DEPTH(2), .HOLD(1), .LATENCY(1), .DATA_W(8), .INIT(8'hC3),
               .INIT_VALID(1'b0), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_data(din_data),
    .din_ready(dinr[2]), .dout_valid(dv[2]), .dout_data(dd[2]),
    .dout_ready(ready), .drop_cnt(c2), .overflow(ov[2]));

  // Per-instance configuration as seen by the model.
  function automatic int cfg_depth(input int i);
    return (i == 2) ? 2 : 4;
  endfunction
  function automatic bit cfg_hold(input int i);
    return (i != 1);
  endfunction
  function automatic bit cfg_lat0(input int i);
    return (i == 0);
  endfunction
  function automatic bit cfg_initv(input int i);
    return (i != 2);
  endfunction
  function automatic logic [7:0] cfg_init(input int i);
    return (i == 2) ? 8'hC3 : 8'h5A;
  endfunction
  function automatic int cfg_cmax(input int i);
    case (i)
      0:       return 65535;
      1:       return 3;
      default: return 7;
    endcase
  endfunction

  typedef struct packed {
    logic [N-1:0]       v;
    logic [N-1:0][7:0]  d;
    logic [N-1:0][15:0] c;
    logic [N-1:0]       o;
  } exp_t;

  exp_t sb[$];

  // Reference state: undelivered samples in arrival order (element 0 is the
  // one being offered), last offered value, whether it may be held, drops.
  logic [7:0] pend [N][8];
  int         plen [N];
  logic [7:0] last [N];
  bit         hl   [N];
  int         dcnt [N];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  // Predict this cycle's outputs, then advance the model across the edge.
  task automatic predict(input bit r, input bit v, input logic [7:0] d, input bit rd);
    exp_t e;
    bit   byp, fresh, took, ovf;
    int   n;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        plen[i] = 0;
        last[i] = cfg_init(i);
        hl[i]   = cfg_initv(i);
        dcnt[i] = 0;
      end
      byp = (plen[i] == 0) && cfg_lat0(i) && v;
      if (plen[i] > 0) begin
        e.v[i] = 1'b1; e.d[i] = pend[i][0];
      end else if (byp) begin
        e.v[i] = 1'b1; e.d[i] = d;
      end else if (cfg_hold(i) && hl[i]) begin
        e.v[i] = 1'b1; e.d[i] = last[i];
      end
      e.c[i] = 16'(dcnt[i]);
      fresh  = (plen[i] > 0) || byp;
      took   = fresh && rd;
      ovf    = 1'b0;
      if (!r) begin
        n = plen[i];
        if (took && n > 0) begin
          for (int k = 0; k < n - 1; k++) pend[i][k] = pend[i][k+1];
          n--;
        end
        if (v && !(byp && rd)) begin
          if (n == cfg_depth(i) + 1) begin
            for (int k = 1; k < n - 1; k++) pend[i][k] = pend[i][k+1];
            n--;
            ovf = 1'b1;
          end
          pend[i][n] = d;
          n++;
        end
        plen[i] = n;
        if (ovf && dcnt[i] < cfg_cmax(i)) dcnt[i]++;
        if (byp && rd) begin
          last[i] = d; hl[i] = 1'b1;
        end else if (plen[i] > 0) begin
          last[i] = pend[i][0]; hl[i] = 1'b1;
        end
        if (e.v[i] && rd) hl[i] = 1'b1;
      end
      e.o[i] = ovf;
    end
    sb.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit rd);
    @(posedge clk);
    #1;
    rst       = r;
    din_valid = v && !r;
    din_data  = d;
    ready     = rd;
    predict(r, v && !r, d, rd);
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          check("din_ready", i, 32'(dinr[i]), 32'd1);
          check("dout_valid", i, 32'(dv[i]), 32'(e.v[i]));
          if (e.v[i]) check("dout_data", i, 32'(dd[i]), 32'(e.d[i]));
          check("drop_cnt", i, 32'(dc[i]), 32'(e.c[i]));
          check("overflow", i, 32'(ov[i]), 32'(e.o[i]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; din_valid = 1'b0; din_data = '0; ready = 1'b0;
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) cyc(0, 0, 8'h00, 1);
    // Back-to-back samples with a willing consumer.
    for (int k = 1; k <= 3; k++) cyc(0, 1, 8'(k), 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 8'h00, 1);
    // Stalled consumer fills the queue and overwrites the oldest.
    for (int k = 10; k <= 16; k++) cyc(0, 1, 8'(k), 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 8'h00, 1);
    // Full queue drained while new samples keep arriving.
    for (int k = 20; k <= 25; k++) cyc(0, 1, 8'(k), 0);
    for (int k = 30; k <= 34; k++) cyc(0, 1, 8'(k), 1);
    for (int k = 0; k < 8; k++) cyc(0, 0, 8'h00, 1);
    // Single sample then idle: held or dropped depending on HOLD.
    cyc(0, 1, 8'h33, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 8'h00, 1);
    // Sustained overflow to reach counter saturation.
    for (int k = 40; k <= 49; k++) cyc(0, 1, 8'(k), 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 8'h00, 1);
    // Random traffic, then random traffic with a mostly stalled consumer.
    for (int k = 0; k < 300; k++)
      cyc(0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    for (int k = 0; k < 200; k++)
      cyc(0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0);
    // Reset in the middle of a stalled burst.
    for (int k = 50; k <= 55; k++) cyc(0, 1, 8'(k), 0);
    for (int k = 0; k < 2; k++) cyc(1, 0, 8'h00, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 8'h00, 1);
    for (int k = 0; k < 60; k++)
      cyc(0, $urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
